// File: rtl/mac_acc_pack.sv
// mac_acc_pack: lane-serial accumulate, normalize, round and pack stage of the FP MAC back end.
// Define MAC_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module mac_acc_pack #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 52
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mul_op,
  input  logic        r0_s,
  input  logic        r1_s,
  input  logic        r2_s,
  input  logic        r3_s,
  input  logic [7:0]  r_e,
  input  logic [7:0]  sft_r0,
  input  logic [7:0]  sft_r1,
  input  logic [7:0]  sft_r2,
  input  logic [7:0]  sft_r3,
  input  logic [23:0] m0_0,
  input  logic [23:0] m0_1,
  input  logic [23:0] m0_2,
  input  logic [23:0] m0_3,
  input  logic [23:0] m1_0,
  input  logic [23:0] m1_1,
  input  logic [23:0] m1_2,
  input  logic [23:0] m1_3,
  input  logic [23:0] m2_0,
  input  logic [23:0] m2_1,
  input  logic [23:0] m2_2,
  input  logic [23:0] m2_3,
  input  logic [23:0] m3_0,
  input  logic [23:0] m3_1,
  input  logic [23:0] m3_2,
  input  logic [23:0] m3_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_op,
  output logic [31:0] result,
  output logic        out_ovf,
  output logic        out_udf
);

  typedef enum logic [1:0] {StIdle, StAcc, StNorm, StOut} state_e;

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               accept;

  logic               op_q;
  logic [LANES-1:0]   s_q;
  logic [7:0]         re_q;
  logic [7:0]         sft_q [LANES];
  logic [23:0]        m_q   [LANES][4];

  logic [LANES-1:0]   s_in;
  logic [7:0]         sft_in [LANES];
  logic [23:0]        m_in   [LANES][4];

  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d, udf_q, udf_d, out_op_q;

  assign s_in      = {r3_s, r2_s, r1_s, r0_s};
  assign sft_in[0] = sft_r0;
  assign sft_in[1] = sft_r1;
  assign sft_in[2] = sft_r2;
  assign sft_in[3] = sft_r3;
  assign m_in[0][0] = m0_0;
  assign m_in[0][1] = m0_1;
  assign m_in[0][2] = m0_2;
  assign m_in[0][3] = m0_3;
  assign m_in[1][0] = m1_0;
  assign m_in[1][1] = m1_1;
  assign m_in[1][2] = m1_2;
  assign m_in[1][3] = m1_3;
  assign m_in[2][0] = m2_0;
  assign m_in[2][1] = m2_1;
  assign m_in[2][2] = m2_2;
  assign m_in[2][3] = m2_3;
  assign m_in[3][0] = m3_0;
  assign m_in[3][1] = m3_1;
  assign m_in[3][2] = m3_2;
  assign m_in[3][3] = m3_3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 1'b0;
      s_q  <= '0;
      re_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        sft_q[i] <= '0;
        for (int j = 0; j < 4; j++) m_q[i][j] <= '0;
      end
    end else if (accept) begin
      op_q <= mul_op;
      s_q  <= s_in;
      re_q <= r_e;
      for (int i = 0; i < LANES; i++) begin
        sft_q[i] <= sft_in[i];
        for (int j = 0; j < 4; j++) m_q[i][j] <= m_in[i][j];
      end
    end
  end

  // Current lane: recombine partial products into a 46-fraction-bit product and align it.
  logic [23:0]      pp0, pp1, pp2, pp3;
  logic [7:0]       sft_cur;
  logic             sgn_cur;
  logic [47:0]      prod, prod_sh;
  logic [ACC_W-1:0] prod_ext;

  always_comb begin
    pp0     = m_q[lane_q][0];
    pp1     = m_q[lane_q][1];
    pp2     = m_q[lane_q][2];
    pp3     = m_q[lane_q][3];
    sft_cur = sft_q[lane_q];
    sgn_cur = s_q[lane_q];
    if (op_q) begin
      prod = {pp3, 24'b0} + ({23'b0, {1'b0, pp1} + {1'b0, pp2}} << 12) + {24'b0, pp0};
    end else begin
      prod = {pp0[21:0], 26'b0};
    end
    prod_sh  = (sft_cur >= 8'd48) ? '0 : (prod >> sft_cur);
    prod_ext = {{(ACC_W-48){1'b0}}, prod_sh};
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          acc_d   = '0;
          lane_d  = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d  = sgn_cur ? (acc_q - prod_ext) : (acc_q + prod_ext);
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'(LANES - 1)) state_d = StNorm;
      end
      StNorm:  state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
    end
  end

  // Normalization: shift the leading one to the MSB so significand bits sit at fixed positions.
  logic               acc_s;
  logic [ACC_W-1:0]   mag, norm;
  logic [5:0]         lead;
  logic signed [9:0]  e_raw, e_fin;
  logic [23:0]        mant;
  logic [24:0]        rnd;
  logic               carry;
  logic [22:0]        frac_sp;
  logic [9:0]         frac_hp;
`ifdef MAC_RNE_EN
  logic               guard, sticky;
`endif

  always_comb begin
    acc_s = acc_q[ACC_W-1];
    mag   = acc_s ? (~acc_q + ACC_W'(1)) : acc_q;
    lead  = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    norm  = mag << (6'(ACC_W - 1) - lead);
    e_raw = signed'(10'({2'b00, re_q}) + 10'({4'b0000, lead}) - 10'd46);
    mant  = op_q ? norm[ACC_W-1 -: 24] : {13'b0, norm[ACC_W-1 -: 11]};
`ifdef MAC_RNE_EN
    guard  = op_q ? norm[ACC_W-25] : norm[ACC_W-12];
    sticky = op_q ? (|norm[ACC_W-26:0]) : (|norm[ACC_W-13:0]);
    rnd    = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
    carry  = op_q ? rnd[24] : rnd[11];
`else
    rnd    = {1'b0, mant};
    carry  = 1'b0;
`endif
    e_fin   = carry ? (e_raw + 10'sd1) : e_raw;
    frac_sp = carry ? '0 : rnd[22:0];
    frac_hp = carry ? '0 : rnd[9:0];

    result_d = '0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (mag == '0) begin
      result_d = '0;
    end else if (e_fin >= (op_q ? 10'sd255 : 10'sd31)) begin
      ovf_d    = 1'b1;
      result_d = op_q ? {acc_s, 8'hFF, 23'b0} : {16'b0, acc_s, 5'h1F, 10'b0};
    end else if (e_fin <= 10'sd0) begin
      udf_d    = 1'b1;
      result_d = op_q ? {acc_s, 31'b0} : {16'b0, acc_s, 15'b0};
    end else begin
      result_d = op_q ? {acc_s, e_fin[7:0], frac_sp} : {16'b0, acc_s, e_fin[4:0], frac_hp};
    end
  end

  // Hidden bits and (in the truncating build) the bits below the kept significand are dropped.
  logic unused_bits;
  assign unused_bits = ^{norm, rnd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      out_op_q <= 1'b0;
    end else if (state_q == StNorm) begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      out_op_q <= op_q;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign result    = result_q;
  assign out_ovf   = ovf_q;
  assign out_udf   = udf_q;
  assign out_op    = out_op_q;

endmodule

// File: tb/tb_mac_acc_pack.sv
// Randomized self-checking bench for mac_acc_pack against an integer-arithmetic reference model.
module tb_mac_acc_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mul_op = 1'b0;
  logic        r0_s = 1'b0, r1_s = 1'b0, r2_s = 1'b0, r3_s = 1'b0;
  logic [7:0]  r_e = '0;
  logic [7:0]  sft_r0 = '0, sft_r1 = '0, sft_r2 = '0, sft_r3 = '0;
  logic [23:0] m0_0 = '0, m0_1 = '0, m0_2 = '0, m0_3 = '0;
  logic [23:0] m1_0 = '0, m1_1 = '0, m1_2 = '0, m1_3 = '0;
  logic [23:0] m2_0 = '0, m2_1 = '0, m2_2 = '0, m2_3 = '0;
  logic [23:0] m3_0 = '0, m3_1 = '0, m3_2 = '0, m3_3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_op;
  logic [31:0] result;
  logic        out_ovf;
  logic        out_udf;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending transaction description
  logic        t_op;
  logic        t_s   [4];
  logic [7:0]  t_re;
  logic [7:0]  t_sft [4];
  logic [23:0] t_m   [4][4];

  mac_acc_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mul_op(mul_op),
    .r0_s(r0_s), .r1_s(r1_s), .r2_s(r2_s), .r3_s(r3_s), .r_e(r_e),
    .sft_r0(sft_r0), .sft_r1(sft_r1), .sft_r2(sft_r2), .sft_r3(sft_r3),
    .m0_0(m0_0), .m0_1(m0_1), .m0_2(m0_2), .m0_3(m0_3),
    .m1_0(m1_0), .m1_1(m1_1), .m1_2(m1_2), .m1_3(m1_3),
    .m2_0(m2_0), .m2_1(m2_1), .m2_2(m2_2), .m2_3(m2_3),
    .m3_0(m3_0), .m3_1(m3_1), .m3_2(m3_2), .m3_3(m3_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .result(result),
    .out_ovf(out_ovf), .out_udf(out_udf)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_txn();
    t_op = 1'b0;
    t_re = '0;
    for (int i = 0; i < 4; i++) begin
      t_s[i] = 1'b0;
      t_sft[i] = '0;
      for (int j = 0; j < 4; j++) t_m[i][j] = '0;
    end
  endtask

  task automatic apply_txn();
    mul_op = t_op; r_e = t_re;
    r0_s = t_s[0]; r1_s = t_s[1]; r2_s = t_s[2]; r3_s = t_s[3];
    sft_r0 = t_sft[0]; sft_r1 = t_sft[1]; sft_r2 = t_sft[2]; sft_r3 = t_sft[3];
    m0_0 = t_m[0][0]; m0_1 = t_m[0][1]; m0_2 = t_m[0][2]; m0_3 = t_m[0][3];
    m1_0 = t_m[1][0]; m1_1 = t_m[1][1]; m1_2 = t_m[1][2]; m1_3 = t_m[1][3];
    m2_0 = t_m[2][0]; m2_1 = t_m[2][1]; m2_2 = t_m[2][2]; m2_3 = t_m[2][3];
    m3_0 = t_m[3][0]; m3_1 = t_m[3][1]; m3_2 = t_m[3][2]; m3_3 = t_m[3][3];
  endtask

  task automatic scramble_inputs();
    mul_op = 1'($urandom); r_e = 8'($urandom);
    r0_s = 1'($urandom); r1_s = 1'($urandom); r2_s = 1'($urandom); r3_s = 1'($urandom);
    sft_r0 = 8'($urandom); sft_r1 = 8'($urandom); sft_r2 = 8'($urandom); sft_r3 = 8'($urandom);
    m0_0 = 24'($urandom); m0_1 = 24'($urandom); m0_2 = 24'($urandom); m0_3 = 24'($urandom);
    m1_0 = 24'($urandom); m1_1 = 24'($urandom); m1_2 = 24'($urandom); m1_3 = 24'($urandom);
    m2_0 = 24'($urandom); m2_1 = 24'($urandom); m2_2 = 24'($urandom); m2_3 = 24'($urandom);
    m3_0 = 24'($urandom); m3_1 = 24'($urandom); m3_2 = 24'($urandom); m3_3 = 24'($urandom);
  endtask

  // Reference: exact integer sum of aligned products, then IEEE-style pack. Returns {ovf, udf, result}.
  function automatic logic [33:0] model();
    longint acc = 0;
    longint p, mag, q;
    int k, nb, e, emax, sh;
    logic s;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      if (t_op) p = (longint'(t_m[i][3]) << 24) +
                    ((longint'(t_m[i][1]) + longint'(t_m[i][2])) << 12) + longint'(t_m[i][0]);
      else      p = longint'(t_m[i][0]) << 26;
      p = p & 64'h0000_FFFF_FFFF_FFFF;
      p = (t_sft[i] >= 8'd48) ? 64'sd0 : (p >>> t_sft[i]);
      acc = t_s[i] ? acc - p : acc + p;
    end
    if (acc == 0) return 34'd0;
    s   = (acc < 0);
    mag = s ? -acc : acc;
    k = 0;
    for (int b = 0; b < 62; b++) if (((mag >> b) & 64'sd1) != 0) k = b;
    nb = t_op ? 24 : 11;
    e  = int'(t_re) + k - 46;
    if (k >= nb - 1) begin
      sh = k - nb + 1;
      q  = mag >> sh;
`ifdef MAC_RNE_EN
      if (sh > 0) begin
        longint rem, half_u;
        rem    = mag - (q << sh);
        half_u = 64'sd1 << (sh - 1);
        if (rem > half_u || (rem == half_u && (q & 64'sd1) != 0)) q = q + 1;
      end
`endif
    end else begin
      q = mag << (nb - 1 - k);
    end
    if (q == (64'sd1 << nb)) begin
      q = q >> 1;
      e = e + 1;
    end
    emax = t_op ? 255 : 31;
    if (e >= emax) begin
      res = t_op ? {s, 8'hFF, 23'b0} : {16'b0, s, 5'h1F, 10'b0};
      return {1'b1, 1'b0, res};
    end
    if (e <= 0) begin
      res = t_op ? {s, 31'b0} : {16'b0, s, 15'b0};
      return {1'b0, 1'b1, res};
    end
    if (t_op) res = {s, 8'(e), 23'(q)};
    else      res = {16'b0, s, 5'(e), 10'(q)};
    return {2'b00, res};
  endfunction

  task automatic accept_txn();
    @(negedge clk);
    check("rdy_idle", 64'(in_ready), 64'd1);
    apply_txn();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Keep garbage and in_valid asserted while busy; the block must ignore them.
    scramble_inputs();
  endtask

  task automatic run_txn(input logic [31:0] exp_res, input logic exp_ovf, input logic exp_udf,
                         input int hold);
    int cyc;
    accept_txn();
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (!out_valid) check("rdy_busy", 64'(in_ready), 64'd0);
    end while (!out_valid && cyc < 20);
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'd5);
    check("excl", 64'(in_ready & out_valid), 64'd0);
    check("result", 64'(result), 64'(exp_res));
    check("ovf", 64'(out_ovf), 64'(exp_ovf));
    check("udf", 64'(out_udf), 64'(exp_udf));
    check("op", 64'(out_op), 64'(t_op));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_rdy", 64'(in_ready), 64'd0);
      check("hold_result", 64'(result), 64'(exp_res));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("back_idle", 64'(in_ready), 64'd1);
    check("valid_drop", 64'(out_valid), 64'd0);
  endtask

  task automatic run_model(input int hold);
    logic [33:0] ex;
    ex = model();
    run_txn(ex[31:0], ex[33], ex[32], hold);
  endtask

  task automatic gen_random();
    logic [23:0] a, b;
    logic [10:0] ah, bh;
    clear_txn();
    t_op = 1'($urandom);
    if (t_op) t_re = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(110, 140));
    else      t_re = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(1, 30));
    for (int i = 0; i < 4; i++) begin
      t_s[i]   = 1'($urandom);
      t_sft[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 4; j++) t_m[i][j] = 24'($urandom);
      end else if (t_op) begin
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
        t_m[i][0] = 24'(a[11:0]) * 24'(b[11:0]);
        t_m[i][1] = 24'(a[11:0]) * 24'(b[23:12]);
        t_m[i][2] = 24'(a[23:12]) * 24'(b[11:0]);
        t_m[i][3] = 24'(a[23:12]) * 24'(b[23:12]);
      end else begin
        ah = {1'b1, 10'($urandom)};
        bh = {1'b1, 10'($urandom)};
        t_m[i][0] = 24'(ah) * 24'(bh);
        for (int j = 1; j < 4; j++) t_m[i][j] = 24'($urandom);
      end
    end
  endtask

  initial begin
    out_ready = 1'b0;
    #12;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({out_op, out_ovf, out_udf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 x 1.0 single, with three cycles of backpressure
    clear_txn(); t_op = 1'b1; t_re = 8'd127; t_m[0][3] = 24'h400000;
    run_txn(32'h3F80_0000, 1'b0, 1'b0, 3);

    // Half cancellation gives +0 without underflow
    clear_txn(); t_re = 8'd15; t_m[0][0] = 24'h100000; t_m[1][0] = 24'h100000; t_s[1] = 1'b1;
    run_txn(32'h0000_0000, 1'b0, 1'b0, 0);

    // Half 1.0
    clear_txn(); t_re = 8'd15; t_m[0][0] = 24'h100000; t_m[2][1] = 24'hABCDEF;
    run_txn(32'h0000_3C00, 1'b0, 1'b0, 0);

    // 1.0 + 0.5 single
    clear_txn(); t_op = 1'b1; t_re = 8'd127; t_m[0][3] = 24'h400000; t_m[1][3] = 24'h400000;
    t_sft[1] = 8'd1;
    run_txn(32'h3FC0_0000, 1'b0, 1'b0, 0);

    // Four lanes of 1.0 at r_e=254 overflows
    clear_txn(); t_op = 1'b1; t_re = 8'd254;
    for (int i = 0; i < 4; i++) t_m[i][3] = 24'h400000;
    run_txn(32'h7F80_0000, 1'b1, 1'b0, 0);

    // Negative exponent underflow keeps sign
    clear_txn(); t_op = 1'b1; t_re = 8'd5; t_m[0][3] = 24'h400000; t_sft[0] = 8'd10; t_s[0] = 1'b1;
    run_txn(32'h8000_0000, 1'b0, 1'b1, 0);

    // Shift of 48 or more discards the lane entirely
    clear_txn(); t_op = 1'b1; t_re = 8'd127; t_m[0][3] = 24'h400000; t_sft[0] = 8'd48;
    run_txn(32'h0000_0000, 1'b0, 1'b0, 0);

    // Reset while lane 2 is being accumulated
    clear_txn(); t_op = 1'b1; t_re = 8'd127;
    for (int i = 0; i < 4; i++) t_m[i][3] = 24'h400000;
    accept_txn();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_txn(); t_op = 1'b1; t_re = 8'd128; t_m[0][3] = 24'h400000; t_m[3][3] = 24'h400000;
    t_sft[3] = 8'd2; t_s[3] = 1'b1;
    run_txn(32'h3FC0_0000, 1'b0, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      gen_random();
      run_model($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
